// File: rtl/mod_exp_arbiter.sv
// Round-robin arbiter sharing one mod_exp core among NREQ requesters; one operation in flight, response returned only to its owner.
// Request accepted in IDLE, operands to core 1 cycle later; a stalled response holds off all new grants. Optional core watchdog: MOD_EXP_ARB_TIMEOUT_EN.
module mod_exp_arbiter #(
    parameter int SIZE = 64,
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ*SIZE-1:0] req_base_tdata,
    input  logic [NREQ*SIZE-1:0] req_power_tdata,
    input  logic [NREQ*SIZE-1:0] req_modulus_tdata,
    input  logic [NREQ-1:0]      req_tvalid,
    output logic [NREQ-1:0]      req_tready,
    output logic [SIZE-1:0]      rsp_tdata,
    output logic                 rsp_err,
    output logic [NREQ-1:0]      rsp_tvalid,
    input  logic [NREQ-1:0]      rsp_tready,
    output logic [SIZE-1:0]      core_base_tdata,
    output logic [SIZE-1:0]      core_power_tdata,
    output logic [SIZE-1:0]      core_modulus_tdata,
    output logic                 core_in_tvalid,
    input  logic                 core_in_tready,
    input  logic [SIZE-1:0]      core_out_tdata,
    input  logic                 core_out_tvalid,
    output logic                 core_out_tready,
    output logic                 core_rst,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [SIZE-1:0] base_q, base_d;
    logic [SIZE-1:0] power_q, power_d;
    logic [SIZE-1:0] modulus_q, modulus_d;
    logic [SIZE-1:0] result_q, result_d;
    logic            err_q, err_d;

    logic [IDW-1:0]  winner;
    logic            any_vld;
    int              idx;
    logic [SIZE-1:0] win_base, win_power, win_modulus;

    logic [NREQ-1:0] req_tready_c, rsp_tvalid_c;
    logic            core_in_tvalid_c, core_out_tready_c;

`ifdef MOD_EXP_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_pulse;
`endif

    // Scan from the far end back toward rr_ptr+1 so the nearest valid requester wins.
    always_comb begin
        winner  = '0;
        any_vld = 1'b0;
        idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_tvalid[idx]) begin
                winner  = IDW'(idx);
                any_vld = 1'b1;
            end
        end
    end

    assign win_base    = req_base_tdata[int'(winner)*SIZE +: SIZE];
    assign win_power   = req_power_tdata[int'(winner)*SIZE +: SIZE];
    assign win_modulus = req_modulus_tdata[int'(winner)*SIZE +: SIZE];

    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        grant_id_d        = grant_id_q;
        base_d            = base_q;
        power_d           = power_q;
        modulus_d         = modulus_q;
        result_d          = result_q;
        err_d             = err_q;
        req_tready_c      = '0;
        rsp_tvalid_c      = '0;
        core_in_tvalid_c  = 1'b0;
        core_out_tready_c = 1'b0;
`ifdef MOD_EXP_ARB_TIMEOUT_EN
        cnt_d             = cnt_q;
        timeout_pulse     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_vld) begin
                    req_tready_c = ONE_HOT0 << winner;
                    grant_id_d   = winner;
                    base_d       = win_base;
                    power_d      = win_power;
                    modulus_d    = win_modulus;
                    // Moduli 0 and 1 are answered locally; the core never sees them.
                    if (win_modulus[SIZE-1:1] == '0) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = S_RETURN;
                    end else begin
                        state_d  = S_ISSUE;
`ifdef MOD_EXP_ARB_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end
                end
            end
            S_ISSUE: begin
                core_in_tvalid_c = 1'b1;
                if (core_in_tready) state_d = S_WAIT;
            end
            S_WAIT: begin
                core_out_tready_c = 1'b1;
                if (core_out_tvalid) begin
                    result_d = core_out_tdata;
                    err_d    = 1'b0;
                    state_d  = S_RETURN;
                end
            end
            default: begin
                rsp_tvalid_c = ONE_HOT0 << grant_id_q;
                if (rsp_tready[grant_id_q]) begin
                    rr_ptr_d = grant_id_q;
                    state_d  = S_IDLE;
                end
            end
        endcase
`ifdef MOD_EXP_ARB_TIMEOUT_EN
        // Watchdog overrides any core handshake in the cycle the core is reset.
        if (state_q == S_ISSUE || state_q == S_WAIT) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'hFFFF) begin
                timeout_pulse     = 1'b1;
                core_in_tvalid_c  = 1'b0;
                core_out_tready_c = 1'b0;
                result_d          = '0;
                err_d             = 1'b1;
                state_d           = S_RETURN;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= IDW'(NREQ - 1);
            grant_id_q <= '0;
            base_q     <= '0;
            power_q    <= '0;
            modulus_q  <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
`ifdef MOD_EXP_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            base_q     <= base_d;
            power_q    <= power_d;
            modulus_q  <= modulus_d;
            result_q   <= result_d;
            err_q      <= err_d;
`ifdef MOD_EXP_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Handshake outputs are masked while rst is high so nothing appears accepted during reset.
    assign req_tready         = rst ? '0 : req_tready_c;
    assign rsp_tvalid         = rst ? '0 : rsp_tvalid_c;
    assign core_in_tvalid     = core_in_tvalid_c & ~rst;
    assign core_out_tready    = core_out_tready_c & ~rst;
    assign busy               = (state_q != S_IDLE) & ~rst;
    assign rsp_tdata          = result_q;
    assign rsp_err            = err_q;
    assign grant_id           = grant_id_q;
    assign core_base_tdata    = base_q;
    assign core_power_tdata   = power_q;
    assign core_modulus_tdata = modulus_q;
`ifdef MOD_EXP_ARB_TIMEOUT_EN
    assign core_rst           = rst | timeout_pulse;
`else
    assign core_rst           = rst;
`endif

endmodule

// File: tb/tb_mod_exp_arbiter.sv
// Directed bench for mod_exp_arbiter: stimulus pushes expected grants/responses into queues, a negedge monitor pops and compares.
module tb_mod_exp_arbiter;
    localparam int SIZE = 64;
    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);

    logic                 clk;
    logic                 rst;
    logic [NREQ*SIZE-1:0] req_base_tdata, req_power_tdata, req_modulus_tdata;
    logic [NREQ-1:0]      req_tvalid, req_tready;
    logic [SIZE-1:0]      rsp_tdata;
    logic                 rsp_err;
    logic [NREQ-1:0]      rsp_tvalid, rsp_tready;
    logic [SIZE-1:0]      core_base_tdata, core_power_tdata, core_modulus_tdata;
    logic                 core_in_tvalid, core_in_tready;
    logic [SIZE-1:0]      core_out_tdata;
    logic                 core_out_tvalid, core_out_tready;
    logic                 core_rst;
    logic [IDW-1:0]       grant_id;
    logic                 busy;

    mod_exp_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_base_tdata(req_base_tdata), .req_power_tdata(req_power_tdata),
        .req_modulus_tdata(req_modulus_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
        .rsp_tdata(rsp_tdata), .rsp_err(rsp_err), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
        .core_base_tdata(core_base_tdata), .core_power_tdata(core_power_tdata),
        .core_modulus_tdata(core_modulus_tdata), .core_in_tvalid(core_in_tvalid),
        .core_in_tready(core_in_tready), .core_out_tdata(core_out_tdata),
        .core_out_tvalid(core_out_tvalid), .core_out_tready(core_out_tready),
        .core_rst(core_rst), .grant_id(grant_id), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          id;
        logic [63:0] dat;
        logic        err;
    } rsp_t;

    rsp_t exp_rsp[$];
    int   exp_grant[$];
    int   n_chk = 0;
    int   n_err = 0;

    int   core_lat  = 2;
    bit   core_mute = 1'b0;
    bit   saw_core_in;
    int   core_rst_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    // Behavioural mod_exp core; the bench's expected values are hand-computed constants.
    function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] p, input logic [63:0] m);
        logic [127:0] r, x, mm;
        mm = {64'd0, m};
        r  = 128'd1 % mm;
        x  = {64'd0, b} % mm;
        for (int i = 0; i < 64; i++) begin
            if (p[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[63:0];
    endfunction

    initial begin
        logic [63:0] cres;
        bit          cbusy;
        int          ccnt;
        core_out_tvalid = 1'b0;
        core_out_tdata  = '0;
        cbusy = 1'b0;
        ccnt  = 0;
        cres  = '0;
        forever begin
            @(negedge clk);
            if (core_rst) begin
                core_out_tvalid = 1'b0;
                cbusy = 1'b0;
            end else begin
                if (!core_out_tvalid && cbusy) begin
                    if (ccnt == 0) begin
                        if (!core_mute) begin
                            core_out_tvalid = 1'b1;
                            core_out_tdata  = cres;
                            cbusy = 1'b0;
                        end
                    end else ccnt--;
                end else if (!core_out_tvalid && core_in_tvalid && core_in_tready) begin
                    cres  = modexp(core_base_tdata, core_power_tdata, core_modulus_tdata);
                    cbusy = 1'b1;
                    ccnt  = core_lat;
                end
                if (core_out_tvalid && core_out_tready) begin
                    @(posedge clk);
                    #1 core_out_tvalid = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [NREQ-1:0] hs;
        rsp_t e;
        int g;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hs = req_tvalid & req_tready;
                if (hs != '0) begin
                    chk("req_tready_onehot", 64'($onehot(req_tready)), 64'd1);
                    if (exp_grant.size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL unexpected_grant: req_tready=%b none expected", req_tready);
                    end else begin
                        g = exp_grant.pop_front();
                        chk("grant", 64'(req_tready), 64'(NREQ'(1) << g));
                    end
                end
                if (rsp_tvalid != '0)
                    chk("rsp_tvalid_onehot", 64'($onehot(rsp_tvalid)), 64'd1);
                if ((rsp_tvalid & rsp_tready) != '0) begin
                    if (exp_rsp.size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL unexpected_rsp: rsp_tvalid=%b data=%0d", rsp_tvalid, rsp_tdata);
                    end else begin
                        e = exp_rsp.pop_front();
                        chk("rsp_owner", 64'(rsp_tvalid), 64'(NREQ'(1) << e.id));
                        chk("rsp_grant_id", 64'(grant_id), 64'(e.id));
                        chk("rsp_tdata", rsp_tdata, e.dat);
                        chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [63:0] b, input logic [63:0] p, input logic [63:0] m);
        req_base_tdata[i*SIZE +: SIZE]    = b;
        req_power_tdata[i*SIZE +: SIZE]   = p;
        req_modulus_tdata[i*SIZE +: SIZE] = m;
        req_tvalid[i] = 1'b1;
    endtask

    task automatic expect_op(input int id, input logic [63:0] dat, input logic err);
        rsp_t e;
        e.id = id; e.dat = dat; e.err = err;
        exp_grant.push_back(id);
        exp_rsp.push_back(e);
    endtask

    // Called between a negedge and the next posedge; retires accepted requests after the edge.
    task automatic step_from_neg();
        logic [NREQ-1:0] hs;
        hs = req_tvalid & req_tready;
        saw_core_in  = saw_core_in | core_in_tvalid;
        if (core_rst && !rst) core_rst_cnt++;
        @(posedge clk);
        #1 req_tvalid = req_tvalid & ~hs;
    endtask

    task automatic step();
        @(negedge clk);
        step_from_neg();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_rsp.size() == 0 && exp_grant.size() == 0 && req_tvalid == '0 && !busy)) begin
            if (n >= budget) begin
                timeout_fail(name);
                exp_rsp.delete();
                exp_grant.delete();
                req_tvalid = '0;
                break;
            end
            step();
            n++;
        end
    endtask

    initial begin
        bit stable, reraised, found;
        rst = 1'b1;
        req_tvalid = '0;
        req_base_tdata = '0;
        req_power_tdata = '0;
        req_modulus_tdata = '0;
        rsp_tready = '1;
        core_in_tready = 1'b1;
        saw_core_in = 1'b0;
        core_rst_cnt = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_tready", 64'(req_tready), 64'd0);
        chk("rst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
        chk("rst_core_in_tvalid", 64'(core_in_tvalid), 64'd0);
        chk("rst_core_out_tready", 64'(core_out_tready), 64'd0);
        chk("rst_core_rst", 64'(core_rst), 64'd1);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_rsp_tdata", rsp_tdata, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("core_rst_release", 64'(core_rst), 64'd0);
        @(posedge clk);
        #1;

        // Single request 4^13 mod 497 = 445
        set_req(0, 64'd4, 64'd13, 64'd497);
        expect_op(0, 64'd445, 1'b0);
        @(negedge clk);
        chk("single_req_tready", 64'(req_tready), 64'b0001);
        step_from_neg();
        @(negedge clk);
        chk("single_core_in_tvalid", 64'(core_in_tvalid), 64'd1);
        chk("single_core_base", core_base_tdata, 64'd4);
        chk("single_core_power", core_power_tdata, 64'd13);
        chk("single_core_modulus", core_modulus_tdata, 64'd497);
        step_from_neg();
        wait_done("single_done", 200);

        // All four valid from reset: grants 0,1,2,3, then re-raised 0
        rst = 1'b1;
        step();
        #1 rst = 1'b0;
        set_req(0, 64'd3, 64'd4, 64'd100);
        set_req(1, 64'd2, 64'd10, 64'd1000);
        set_req(2, 64'd5, 64'd3, 64'd13);
        set_req(3, 64'd7, 64'd2, 64'd10);
        expect_op(0, 64'd81, 1'b0);
        expect_op(1, 64'd24, 1'b0);
        expect_op(2, 64'd8, 1'b0);
        expect_op(3, 64'd9, 1'b0);
        expect_op(0, 64'd4, 1'b0);
        reraised = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (exp_rsp.size() == 0 && exp_grant.size() == 0 && req_tvalid == '0 && !busy) break;
            if (n == 599) timeout_fail("rr_done");
            step();
            if (!reraised && !req_tvalid[0]) begin
                set_req(0, 64'd2, 64'd5, 64'd7);
                reraised = 1'b1;
            end
        end

        // Modulus 1 and modulus 0 never reach the core
        saw_core_in = 1'b0;
        set_req(1, 64'd9, 64'd9, 64'd1);
        expect_op(1, 64'd0, 1'b1);
        wait_done("mod1_done", 100);
        chk("mod1_no_core", 64'(saw_core_in), 64'd0);
        saw_core_in = 1'b0;
        set_req(2, 64'd9, 64'd9, 64'd0);
        expect_op(2, 64'd0, 1'b1);
        wait_done("mod0_done", 100);
        chk("mod0_no_core", 64'(saw_core_in), 64'd0);

        // Response backpressure on requester 2 blocks requester 3
        rsp_tready = 4'b1011;
        set_req(2, 64'd5, 64'd3, 64'd13);
        expect_op(2, 64'd8, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rsp_tvalid[2]) begin found = 1'b1; break; end
            step_from_neg();
        end
        chk("bp_rsp_reached", 64'(found), 64'd1);
        step_from_neg();
        set_req(3, 64'd7, 64'd2, 64'd10);
        expect_op(3, 64'd9, 1'b0);
        stable = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            stable &= (rsp_tvalid == 4'b0100) && (rsp_tdata == 64'd8) && !rsp_err && (req_tready == '0);
            step_from_neg();
        end
        chk("bp_hold_stable", 64'(stable), 64'd1);
        rsp_tready = '1;
        step();
        @(negedge clk);
        chk("bp_release_grant", 64'(req_tready), 64'b1000);
        step_from_neg();
        wait_done("bp_done", 200);

        // Move rr_ptr to 1, then reset while a core result is pending in WAIT
        set_req(1, 64'd2, 64'd5, 64'd7);
        expect_op(1, 64'd4, 1'b0);
        wait_done("pre_rst_done", 200);
        core_lat = 6;
        set_req(2, 64'd3, 64'd4, 64'd100);
        exp_grant.push_back(2);
        found = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            #1;
            if (core_out_tvalid && core_out_tready) begin found = 1'b1; break; end
            step_from_neg();
        end
        chk("wait_result_pending", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
        chk("midrst_core_in_tvalid", 64'(core_in_tvalid), 64'd0);
        core_lat = 2;
        @(posedge clk);
        #1;
        set_req(0, 64'd2, 64'd10, 64'd1000);
        set_req(3, 64'd3, 64'd4, 64'd100);
        expect_op(0, 64'd24, 1'b0);
        expect_op(3, 64'd81, 1'b0);
        @(negedge clk);
        chk("post_rst_first_grant", 64'(req_tready), 64'b0001);
        step_from_neg();
        wait_done("post_rst_done", 300);

`ifdef MOD_EXP_ARB_TIMEOUT_EN
        // Silent core: watchdog resets it once and returns an error to the owner
        core_mute = 1'b1;
        core_rst_cnt = 0;
        set_req(1, 64'd2, 64'd3, 64'd5);
        expect_op(1, 64'd0, 1'b1);
        wait_done("timeout_done", 70000);
        chk("timeout_core_rst_pulses", 64'(core_rst_cnt), 64'd1);
        core_mute = 1'b0;
        set_req(2, 64'd2, 64'd3, 64'd5);
        set_req(0, 64'd3, 64'd3, 64'd5);
        expect_op(2, 64'd3, 1'b0);
        expect_op(0, 64'd2, 1'b0);
        wait_done("after_timeout_done", 300);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
